// File: rtl/bfly_stage.sv
// Radix-2 butterfly stage: emits a+b rows as they arrive, stores a-b rows,
// then drains the stored difference rows back-to-back.
module bfly_stage #(
  parameter int DATA_WIDTH = 9,
  parameter int IN_SIZE    = 16,
  parameter int SIZE       = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         bfly_en,
  input  logic signed [DATA_WIDTH-1:0] a_i    [0:IN_SIZE-1],
  input  logic signed [DATA_WIDTH-1:0] a_q    [0:IN_SIZE-1],
  input  logic signed [DATA_WIDTH-1:0] b_i    [0:IN_SIZE-1],
  input  logic signed [DATA_WIDTH-1:0] b_q    [0:IN_SIZE-1],
  output logic signed [DATA_WIDTH:0]   dout_i [0:IN_SIZE-1],
  output logic signed [DATA_WIDTH:0]   dout_q [0:IN_SIZE-1],
  output logic                         dout_valid,
  output logic                         dout_half,
  output logic [$clog2(SIZE)-1:0]      dout_idx,
  output logic                         busy,
  output logic                         overrun
);

  localparam int OW    = DATA_WIDTH + 1;
  localparam int CNT_W = $clog2(SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

  typedef enum logic {ST_SUM, ST_DIFF} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             acc_p0;
  logic             drain_p0;

  logic signed [OW-1:0] dbuf_i [0:SIZE-1][0:IN_SIZE-1];
  logic signed [OW-1:0] dbuf_q [0:SIZE-1][0:IN_SIZE-1];

  // Exact sum with one bit of growth (both operands sign-extended first).
  function automatic logic signed [OW-1:0] ext_add(input logic signed [DATA_WIDTH-1:0] x,
                                                   input logic signed [DATA_WIDTH-1:0] y);
    ext_add = $signed({x[DATA_WIDTH-1], x}) + $signed({y[DATA_WIDTH-1], y});
  endfunction

  // Exact difference with one bit of growth (both operands sign-extended first).
  function automatic logic signed [OW-1:0] ext_sub(input logic signed [DATA_WIDTH-1:0] x,
                                                   input logic signed [DATA_WIDTH-1:0] y);
    ext_sub = $signed({x[DATA_WIDTH-1], x}) - $signed({y[DATA_WIDTH-1], y});
  endfunction

  // Next-state and row-counter logic; drain in DIFF is unconditional.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    acc_p0   = 1'b0;
    drain_p0 = 1'b0;
    case (state)
      ST_SUM: begin
        if (bfly_en) begin
          acc_p0 = 1'b1;
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = ST_DIFF;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      ST_DIFF: begin
        drain_p0 = 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_SUM;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_SUM;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register, row counter and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_SUM;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == ST_DIFF && bfly_en) overrun <= 1'b1;
    end
  end

  // Difference-row store; contents are don't-care until written in SUM.
  always_ff @(posedge clk) begin
    if (acc_p0) begin
      for (int l = 0; l < IN_SIZE; l++) begin
        dbuf_i[cnt][l] <= ext_sub(a_i[l], b_i[l]);
        dbuf_q[cnt][l] <= ext_sub(a_q[l], b_q[l]);
      end
    end
  end

  // ---- output register stage: sum row on accept, stored row on drain ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout_valid <= 1'b0;
      dout_half  <= 1'b0;
      dout_idx   <= '0;
      for (int l = 0; l < IN_SIZE; l++) begin
        dout_i[l] <= '0;
        dout_q[l] <= '0;
      end
    end else begin
      dout_valid <= acc_p0 | drain_p0;
      if (acc_p0) begin
        dout_half <= 1'b0;
        dout_idx  <= cnt;
        for (int l = 0; l < IN_SIZE; l++) begin
          dout_i[l] <= ext_add(a_i[l], b_i[l]);
          dout_q[l] <= ext_add(a_q[l], b_q[l]);
        end
      end else if (drain_p0) begin
        dout_half <= 1'b1;
        dout_idx  <= cnt;
        for (int l = 0; l < IN_SIZE; l++) begin
          dout_i[l] <= dbuf_i[cnt][l];
          dout_q[l] <= dbuf_q[cnt][l];
        end
      end
    end
  end

  assign busy = (state == ST_DIFF);

endmodule

// File: tb/tb_bfly_stage.sv
// Randomized bench for bfly_stage against a queue-based frame model.
module tb_bfly_stage;

  localparam int DW = 9;
  localparam int NL = 16;
  localparam int SZ = 16;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 bfly_en;
  logic signed [DW-1:0] a_i [0:NL-1];
  logic signed [DW-1:0] a_q [0:NL-1];
  logic signed [DW-1:0] b_i [0:NL-1];
  logic signed [DW-1:0] b_q [0:NL-1];
  logic signed [DW:0]   dout_i [0:NL-1];
  logic signed [DW:0]   dout_q [0:NL-1];
  logic                 dout_valid;
  logic                 dout_half;
  logic [3:0]           dout_idx;
  logic                 busy;
  logic                 overrun;

  int n_checks = 0;
  int n_errors = 0;

  // expected outputs
  int e_i [NL];
  int e_q [NL];
  int e_valid, e_half, e_idx, e_busy, e_ovr;

  // frame model: accepted-row count, pending difference rows (lane-major in queues)
  int m_acc;
  int m_drain;
  int m_didx;
  int dq_i [$];
  int dq_q [$];

  bfly_stage #(.DATA_WIDTH(DW), .IN_SIZE(NL), .SIZE(SZ)) dut (
    .clk(clk), .rstn(rstn), .bfly_en(bfly_en),
    .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
    .dout_i(dout_i), .dout_q(dout_q),
    .dout_valid(dout_valid), .dout_half(dout_half), .dout_idx(dout_idx),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model update for one rising edge, using the inputs presented at that edge.
  task automatic model_edge();
    if (!rstn) begin
      m_acc = 0; m_drain = 0; m_didx = 0;
      dq_i.delete(); dq_q.delete();
      e_valid = 0; e_half = 0; e_idx = 0; e_ovr = 0;
      for (int l = 0; l < NL; l++) begin e_i[l] = 0; e_q[l] = 0; end
    end else if (m_drain == 0) begin
      if (bfly_en) begin
        for (int l = 0; l < NL; l++) begin
          e_i[l] = int'(a_i[l]) + int'(b_i[l]);
          e_q[l] = int'(a_q[l]) + int'(b_q[l]);
          dq_i.push_back(int'(a_i[l]) - int'(b_i[l]));
          dq_q.push_back(int'(a_q[l]) - int'(b_q[l]));
        end
        e_valid = 1; e_half = 0; e_idx = m_acc;
        m_acc++;
        if (m_acc == SZ) begin m_acc = 0; m_drain = 1; m_didx = 0; end
      end else begin
        e_valid = 0;
      end
    end else begin
      if (bfly_en) e_ovr = 1;
      for (int l = 0; l < NL; l++) begin
        e_i[l] = dq_i.pop_front();
        e_q[l] = dq_q.pop_front();
      end
      e_valid = 1; e_half = 1; e_idx = m_didx;
      m_didx++;
      if (dq_i.size() == 0) m_drain = 0;
    end
    e_busy = m_drain;
  endtask

  task automatic check_outputs();
    chk("dout_valid", int'(dout_valid), e_valid);
    chk("busy", int'(busy), e_busy);
    chk("overrun", int'(overrun), e_ovr);
    chk("dout_half", int'(dout_half), e_half);
    chk("dout_idx", int'(dout_idx), e_idx);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("dout_i[%0d]", l), int'(dout_i[l]), e_i[l]);
      chk($sformatf("dout_q[%0d]", l), int'(dout_q[l]), e_q[l]);
    end
  endtask

  // One clock: inputs already set, model follows the edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_rand_row();
    for (int l = 0; l < NL; l++) begin
      a_i[l] = DW'($urandom); a_q[l] = DW'($urandom);
      b_i[l] = DW'($urandom); b_q[l] = DW'($urandom);
    end
  endtask

  task automatic set_extreme_row();
    for (int l = 0; l < NL; l++) begin
      a_i[l] = ($urandom_range(0, 1) != 0) ? 9'h0FF : 9'h100;
      b_i[l] = ($urandom_range(0, 1) != 0) ? 9'h0FF : 9'h100;
      a_q[l] = ($urandom_range(0, 1) != 0) ? 9'h0FF : 9'h100;
      b_q[l] = ($urandom_range(0, 1) != 0) ? 9'h0FF : 9'h100;
    end
  endtask

  task automatic rand_frame();
    for (int r = 0; r < SZ; r++) begin
      bfly_en = 1'b1; set_rand_row(); step();
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bfly_en = 1'b0; set_rand_row(); step();
    end
  endtask

  initial begin
    rstn = 1'b0; bfly_en = 1'b0;
    set_rand_row();
    // reset held for 3 cycles, then idle
    for (int k = 0; k < 3; k++) step();
    rstn = 1'b1;
    idle(5);

    // ramp frame: a=r, b=2r, Q=-I; sums 3r/-3r, diffs -r/r
    for (int r = 0; r < SZ; r++) begin
      bfly_en = 1'b1;
      for (int l = 0; l < NL; l++) begin
        a_i[l] = DW'(r); b_i[l] = DW'(2 * r);
        a_q[l] = DW'(-r); b_q[l] = DW'(-2 * r);
      end
      step();
      chk("ramp_sum_i", int'(dout_i[r % NL]), 3 * r);
    end
    for (int r = 0; r < SZ; r++) begin
      bfly_en = 1'b0; step();
      chk("ramp_diff_i", int'(dout_i[0]), -r);
      chk("ramp_diff_q", int'(dout_q[NL - 1]), r);
    end
    idle(2);

    // extreme operands: sums -512..510, diffs -511..511
    for (int r = 0; r < SZ; r++) begin
      bfly_en = 1'b1; set_extreme_row(); step();
    end
    idle(SZ + 2);

    // gapped input 1,0,0 until 16 rows accepted; drain follows without en
    for (int r = 0; r < SZ; r++) begin
      bfly_en = 1'b1; set_rand_row(); step();
      if (r != SZ - 1) idle(2);
    end
    idle(SZ + 1);

    // overrun during drain, then a frame starting right after the drain
    rand_frame();
    rand_frame();   // these 16 cycles fall in DIFF: discarded, set overrun
    rand_frame();   // accepted back-to-back
    idle(SZ + 2);

    // mid-drain reset, then a fresh frame
    rand_frame();
    idle(5);
    rstn = 1'b0; bfly_en = 1'b0; step();
    rstn = 1'b1;
    idle(3);
    rand_frame();
    idle(SZ + 2);

    // random enables
    for (int k = 0; k < 200; k++) begin
      bfly_en = ($urandom_range(0, 3) != 0); set_rand_row(); step();
    end
    idle(SZ + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
